// File: rtl/wb_load_commit_pkg.sv
// Shared core definitions used by the write-back stage: load-op encodings
// and register-file index width.
package wb_load_commit_pkg;

  localparam int unsigned GPR_W = 5;

  typedef enum logic [2:0] {
    LOP_LW  = 3'd0,
    LOP_LB  = 3'd1,
    LOP_LBU = 3'd2,
    LOP_LH  = 3'd3,
    LOP_LHU = 3'd4
  } load_op_e;

endpackage

// File: rtl/load_align_ext.sv
// Selects the addressed byte/half of a read-data word and sign- or
// zero-extends it to 32 bits. Purely combinational.
module load_align_ext
  import wb_load_commit_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_load_op,
  output logic [31:0] o_value
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    unique case (i_addr_lo)
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      2'd3: w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
  end

  // addr_lo[0] is ignored for halves; misalignment is trapped upstream.
  assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_value = i_rdata;
    case (i_load_op)
      LOP_LW:  o_value = i_rdata;
      LOP_LB:  o_value = {{24{w_byte[7]}}, w_byte};
      LOP_LBU: o_value = {24'd0, w_byte};
      LOP_LH:  o_value = {{16{w_half[15]}}, w_half};
      LOP_LHU: o_value = {16'd0, w_half};
      default: o_value = i_rdata;
    endcase
  end

endmodule

// File: rtl/wb_load_commit.sv
// Write-back stage: holds one instruction, commits ALU results at once and
// stalls loads until read data returns; discards data owed to flushed loads.
module wb_load_commit
  import wb_load_commit_pkg::*;
#(
  parameter int unsigned DROP_W = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             ms_to_ws_valid,
  output logic             ws_allowin,
  input  logic [31:0]      ms_pc,
  input  logic             ms_gr_we,
  input  logic [GPR_W-1:0] ms_dest,
  input  logic [31:0]      ms_result,
  input  logic             ms_is_load,
  input  logic [2:0]       ms_load_op,
  input  logic [1:0]       ms_addr_lo,
  input  logic             data_data_ok,
  input  logic [31:0]      data_rdata,
  input  logic             ws_flush,
  output logic             rf_we,
  output logic [GPR_W-1:0] rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic             ws_busy,
  output logic [GPR_W-1:0] ws_dest,
  output logic [31:0]      debug_wb_pc,
  output logic [3:0]       debug_wb_rf_wen,
  output logic [GPR_W-1:0] debug_wb_rf_wnum,
  output logic [31:0]      debug_wb_rf_wdata
);

  logic              r_valid;
  logic [31:0]       r_pc;
  logic              r_gr_we;
  logic [GPR_W-1:0]  r_dest;
  logic [31:0]       r_result;
  logic              r_is_load;
  logic [2:0]        r_load_op;
  logic [1:0]        r_addr_lo;
  logic [DROP_W-1:0] r_drop_cnt;
  logic [DROP_W-1:0] w_drop_cnt_nxt;

  logic        w_drop_zero;
  logic        w_ld_data;
  logic        w_commit;
  logic        w_accept;
  logic        w_flush_wait;
  logic        w_drop_inc;
  logic        w_drop_dec;
  logic        w_dest_nz;
  logic [31:0] w_ld_value;

  assign w_drop_zero  = (r_drop_cnt == '0);
  assign w_ld_data    = data_data_ok & w_drop_zero;
  assign w_commit     = r_valid & ~ws_flush & (~r_is_load | w_ld_data);
  assign ws_allowin   = ~r_valid | w_commit | ws_flush;
  assign w_accept     = ms_to_ws_valid & ws_allowin & ~ws_flush;
  assign w_flush_wait = r_valid & r_is_load & ws_flush;

  // A beat arriving as the owning load is flushed is simply discarded.
  assign w_drop_inc = w_flush_wait & ~w_ld_data;
  assign w_drop_dec = data_data_ok & ~w_drop_zero;

  always_comb begin
    w_drop_cnt_nxt = r_drop_cnt;
    if (w_drop_inc && !w_drop_dec) begin
      w_drop_cnt_nxt = r_drop_cnt + DROP_W'(1);
    end else if (w_drop_dec && !w_drop_inc) begin
      w_drop_cnt_nxt = r_drop_cnt - DROP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_gr_we    <= 1'b0;
      r_dest     <= '0;
      r_result   <= '0;
      r_is_load  <= 1'b0;
      r_load_op  <= '0;
      r_addr_lo  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_valid   <= 1'b1;
        r_pc      <= ms_pc;
        r_gr_we   <= ms_gr_we;
        r_dest    <= ms_dest;
        r_result  <= ms_result;
        r_is_load <= ms_is_load;
        r_load_op <= ms_load_op;
        r_addr_lo <= ms_addr_lo;
      end else if (w_commit || ws_flush) begin
        r_valid <= 1'b0;
      end
      r_drop_cnt <= w_drop_cnt_nxt;
    end
  end

  load_align_ext u_align (
    .i_rdata   (data_rdata),
    .i_addr_lo (r_addr_lo),
    .i_load_op (r_load_op),
    .o_value   (w_ld_value)
  );

  assign w_dest_nz = (r_dest != '0);
  assign rf_we     = w_commit & r_gr_we & w_dest_nz;
  assign rf_waddr  = r_dest;
  assign rf_wdata  = r_is_load ? w_ld_value : r_result;
  assign ws_busy   = r_valid & r_gr_we & w_dest_nz;
  assign ws_dest   = r_dest;

  assign debug_wb_pc       = r_pc;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

  a_no_drop_overflow : assert property (@(posedge clk) disable iff (!resetn)
    w_flush_wait |-> (r_drop_cnt != '1));

endmodule
